// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared op codes and vector record layout for the calc self-test driver
package calc_pkg;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_SLT = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRA = 3'b110;
   localparam logic [2:0] OP_XOR = 3'b111;

   localparam int VEC_W = 35;

   typedef struct packed {
      logic [2:0]  op;
      logic [15:0] sw;
      logic [15:0] exp;
   } vec_t;

endpackage

// File: rtl/calc_driver_if.sv
// rtl/calc_driver_if.sv - button/switch/led bundle between the driver and the calc block
interface calc_driver_if;

   logic [15:0] led;
   logic        btnu;
   logic        btnl;
   logic        btnc;
   logic        btnr;
   logic        btnd;
   logic [15:0] sw;

   modport master (input led, output btnu, btnl, btnc, btnr, btnd, sw);
   modport slave  (output led, input btnu, btnl, btnc, btnr, btnd, sw);

endinterface

// File: rtl/calc_vec_rom.sv
// rtl/calc_vec_rom.sv - combinational table of ALU vectors, zero beyond the last entry
module calc_vec_rom
   import calc_pkg::*;
#(
   parameter int NUM_VEC = 9,
   parameter int IDX_W   = 4
) (
   input  logic [IDX_W-1:0] idx,
   output vec_t             vec
);

   // Expected values chain: each entry assumes the accumulator left by the previous one.
   always_comb begin
      vec = '0;
      if (int'(idx) < NUM_VEC) begin
         case (int'(idx))
            0: vec = {OP_ADD, 16'h354a, 16'h354a};
            1: vec = {OP_SUB, 16'h1234, 16'h2316};
            2: vec = {OP_OR,  16'h1001, 16'h3317};
            3: vec = {OP_AND, 16'hf0f0, 16'h3010};
            4: vec = {OP_XOR, 16'h1fa2, 16'h2fb2};
            5: vec = {OP_ADD, 16'h6aa2, 16'h9a54};
            6: vec = {OP_SLL, 16'h0004, 16'ha540};
            7: vec = {OP_SRA, 16'h0001, 16'hd2a0};
            8: vec = {OP_SLT, 16'h46ff, 16'h0001};
            default: vec = '0;
         endcase
      end
   end

endmodule

// File: rtl/calc_driver.sv
// rtl/calc_driver.sv - resets calc, replays the vector table and tallies mismatches on led
module calc_driver
   import calc_pkg::*;
#(
   parameter int NUM_VEC       = 9,
   parameter int RST_CYCLES    = 2,
   parameter int SETUP_CYCLES  = 1,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   calc_driver_if.master       calc,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [7:0]          err_count,
   output logic [3:0]          fail_idx
);

   localparam int IDX_W = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
   localparam int CNT_W = 8;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RESET  = 3'd1;
   localparam logic [2:0] S_SETUP  = 3'd2;
   localparam logic [2:0] S_STROBE = 3'd3;
   localparam logic [2:0] S_SETTLE = 3'd4;
   localparam logic [2:0] S_CHECK  = 3'd5;
   localparam logic [2:0] S_DONE   = 3'd6;

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_VEC - 1);

   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] rom_idx;
   vec_t             rom_vec;
   logic [2:0]       op_q;
   logic [15:0]      sw_q;
   logic [15:0]      exp_q;
   logic             mismatch;

   // In CHECK the ROM already looks one entry ahead so the next SETUP can load from it.
   assign rom_idx  = (state == S_CHECK) ? IDX_W'(idx + 1'b1) : idx;
   assign mismatch = (calc.led != exp_q);

   calc_vec_rom #(.NUM_VEC(NUM_VEC), .IDX_W(IDX_W)) u_rom (
      .idx (rom_idx),
      .vec (rom_vec)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         idx       <= '0;
         op_q      <= '0;
         sw_q      <= '0;
         exp_q     <= '0;
         err_count <= '0;
         fail_idx  <= '0;
         pass      <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state     <= S_RESET;
                  cnt       <= '0;
                  idx       <= '0;
                  err_count <= '0;
                  fail_idx  <= '0;
                  pass      <= 1'b0;
               end
            end
            S_RESET: begin
               if (cnt == RST_LAST) begin
                  state <= S_SETUP;
                  cnt   <= '0;
                  op_q  <= rom_vec.op;
                  sw_q  <= rom_vec.sw;
                  exp_q <= rom_vec.exp;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_SETUP: begin
               if (cnt == SETUP_LAST) begin
                  state <= S_STROBE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_STROBE: begin
               state <= S_SETTLE;
               cnt   <= '0;
            end
            S_SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  state <= S_CHECK;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_CHECK: begin
               if (mismatch) begin
                  if (err_count != 8'hff) err_count <= err_count + 8'd1;
                  if (err_count == 8'd0)  fail_idx  <= 4'(idx);
               end
               if (idx == IDX_LAST) begin
                  state <= S_DONE;
                  op_q  <= '0;
                  sw_q  <= '0;
                  pass  <= (err_count == 8'd0) && !mismatch;
               end else begin
                  state <= S_SETUP;
                  cnt   <= '0;
                  idx   <= idx + 1'b1;
                  op_q  <= rom_vec.op;
                  sw_q  <= rom_vec.sw;
                  exp_q <= rom_vec.exp;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy = (state == S_RESET) || (state == S_SETUP) || (state == S_STROBE) ||
                 (state == S_SETTLE) || (state == S_CHECK);
   assign done = (state == S_DONE);

   assign calc.btnu = (state == S_RESET);
   assign calc.btnd = (state == S_STROBE);
   assign {calc.btnl, calc.btnc, calc.btnr} = op_q;
   assign calc.sw   = sw_q;

endmodule
